// File: rtl/demux5_pkg.sv
// demux5_pkg: shared destination-select type and select validity check
// for the demux5_buf 1-to-5 distributing stage.
package demux5_pkg;

  localparam int NUM_DEST = 5;
  localparam int SEL_W    = 3;

  typedef logic [SEL_W-1:0] dest_sel_t;

  localparam dest_sel_t MAX_SEL = dest_sel_t'(NUM_DEST - 1);

  // Selects 0..NUM_DEST-1 name a real destination; the rest are dropped.
  function automatic logic sel_is_valid(dest_sel_t sel);
    return sel <= MAX_SEL;
  endfunction

endpackage

// File: rtl/demux5_if.sv
// demux5_if: valid/ready bundle for demux5_buf. One producer-side input
// channel carrying {data, sel}, and five consumer-side outputs that share
// a single data bus.
interface demux5_if
  import demux5_pkg::*;
#(
  parameter int WIDTH = 32
);

  logic                in_valid;
  logic                in_ready;
  logic [WIDTH-1:0]    in_data;
  dest_sel_t           in_sel;
  logic [NUM_DEST-1:0] out_valid;
  logic [NUM_DEST-1:0] out_ready;
  logic [WIDTH-1:0]    out_data;

  // Producer + consumers side (drives words in, drives ready back).
  modport master (
    output in_valid, in_data, in_sel, out_ready,
    input  in_ready, out_valid, out_data
  );

  // Demultiplexer side.
  modport slave (
    input  in_valid, in_data, in_sel, out_ready,
    output in_ready, out_valid, out_data
  );

endinterface

// File: rtl/demux5_slot.sv
// demux5_slot: one buffer entry {valid, sel, data}. Load has priority over
// clear so a drain and a refill on the same edge keep the entry occupied.
module demux5_slot
  import demux5_pkg::*;
#(
  parameter int WIDTH = 32
) (
  input  logic             clk,
  input  logic             reset_n,
  input  logic             load,
  input  logic             clear,
  input  dest_sel_t        d_sel,
  input  logic [WIDTH-1:0] d_data,
  output logic             vld,
  output dest_sel_t        sel,
  output logic [WIDTH-1:0] data
);

  // Entry state: capture on load, release on clear, empty on reset.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      vld  <= 1'b0;
      sel  <= '0;
      data <= '0;
    end else if (load) begin
      vld  <= 1'b1;
      sel  <= d_sel;
      data <= d_data;
    end else if (clear) begin
      vld  <= 1'b0;
    end
  end

endmodule

// File: rtl/demux5_buf.sv
// demux5_buf: registered 1-to-5 demultiplexer with strict in-order
// delivery and a saturating counter of words dropped for an invalid select.
// Optional feature macro: DEMUX5_SKID_EN adds a second (skid) entry so that
// in_ready comes from a register instead of from out_ready.
module demux5_buf
  import demux5_pkg::*;
#(
  parameter int WIDTH = 32,
  parameter int CNT_W = 8
) (
  input  logic             clk,
  input  logic             reset_n,
  demux5_if.slave          bus,
  output logic [CNT_W-1:0] drop_cnt,
  output logic             drop_pulse
);

  function automatic logic [CNT_W-1:0] sat_inc(logic [CNT_W-1:0] v);
    return (&v) ? v : v + 1'b1;
  endfunction

  logic             rdy_q;
  logic             acc;
  logic             acc_keep;
  logic             acc_drop;
  logic             deliver;

  logic             head_vld;
  dest_sel_t        head_sel;
  logic [WIDTH-1:0] head_data;
  logic             head_load;
  logic             head_clear;
  dest_sel_t        head_d_sel;
  logic [WIDTH-1:0] head_d_data;

  assign acc      = bus.in_valid && bus.in_ready;
  assign acc_keep = acc && sel_is_valid(bus.in_sel);
  assign acc_drop = acc && !sel_is_valid(bus.in_sel);
  // Only the selected destination's ready matters.
  assign deliver  = head_vld && bus.out_ready[head_sel];

`ifdef DEMUX5_SKID_EN
  logic             skid_vld;
  dest_sel_t        skid_sel;
  logic [WIDTH-1:0] skid_data;
  logic             head_free;

  // Head is free for refill when empty or draining this edge. The skid only
  // ever holds a word while the head is occupied, so it always feeds the head
  // first to keep ordering.
  assign head_free   = !head_vld || deliver;
  assign bus.in_ready = rdy_q && !skid_vld;
  assign head_load   = head_free && (skid_vld || acc_keep);
  assign head_clear  = deliver;
  assign head_d_sel  = skid_vld ? skid_sel  : bus.in_sel;
  assign head_d_data = skid_vld ? skid_data : bus.in_data;

  demux5_slot #(.WIDTH(WIDTH)) u_skid (
    .clk     (clk),
    .reset_n (reset_n),
    .load    (acc_keep && !head_free),
    .clear   (skid_vld && head_free),
    .d_sel   (bus.in_sel),
    .d_data  (bus.in_data),
    .vld     (skid_vld),
    .sel     (skid_sel),
    .data    (skid_data)
  );
`else
  // Single entry: accept when empty or when the head leaves on this edge.
  assign bus.in_ready = rdy_q && (!head_vld || deliver);
  assign head_load   = acc_keep;
  assign head_clear  = deliver;
  assign head_d_sel  = bus.in_sel;
  assign head_d_data = bus.in_data;
`endif

  demux5_slot #(.WIDTH(WIDTH)) u_head (
    .clk     (clk),
    .reset_n (reset_n),
    .load    (head_load),
    .clear   (head_clear),
    .d_sel   (head_d_sel),
    .d_data  (head_d_data),
    .vld     (head_vld),
    .sel     (head_sel),
    .data    (head_data)
  );

  // One-hot decode of the head entry onto the five outputs.
  assign bus.out_valid = head_vld ? (NUM_DEST'(1) << head_sel) : '0;
  assign bus.out_data  = head_data;

  // in_ready stays low in reset and opens on the first edge after release.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) rdy_q <= 1'b0;
    else          rdy_q <= 1'b1;
  end

  // Drop accounting: saturating count plus a one-cycle pulse per dropped word.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      drop_cnt   <= '0;
      drop_pulse <= 1'b0;
    end else begin
      drop_pulse <= acc_drop;
      if (acc_drop) drop_cnt <= sat_inc(drop_cnt);
    end
  end

endmodule

// File: tb/tb_demux5_buf.sv
// tb_demux5_buf: table-driven directed vectors plus a randomized stream
// checked against a queue-based reference of the demultiplexer.
module tb_demux5_buf;
  import demux5_pkg::*;

  localparam int WIDTH = 32;
  localparam int CNT_W = 8;

  logic clk = 1'b0;
  logic reset_n;
  always #5 clk = ~clk;

  demux5_if #(.WIDTH(WIDTH)) bus ();
  logic [CNT_W-1:0] drop_cnt;
  logic             drop_pulse;

  demux5_buf #(.WIDTH(WIDTH), .CNT_W(CNT_W)) dut (
    .clk        (clk),
    .reset_n    (reset_n),
    .bus        (bus),
    .drop_cnt   (drop_cnt),
    .drop_pulse (drop_pulse)
  );

  typedef struct {
    logic [2:0]  sel;
    logic [31:0] data;
    logic [4:0]  exp_valid;
    logic [31:0] exp_data;
    logic        exp_pulse;
  } vec_t;

  typedef struct {
    logic [2:0]  sel;
    logic [31:0] data;
  } ent_t;

  int   checks = 0;
  int   errors = 0;
  vec_t tbl[8];
  ent_t q[$];
  int   sent;
  int   cyc;
  bit   acc;
  bit   del;
  bit   exp_rdy;
  logic [4:0] expv;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: actual=%0h required=%0h", name, act, exp);
    end
  endtask

  task automatic cycle();
    @(posedge clk);
    #2;
  endtask

  initial begin
    #600000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1);
  end

  initial begin
    for (int i = 0; i < 5; i++)
      tbl[i] = '{3'(i), 32'(1) << i, 5'(1) << i, 32'(1) << i, 1'b0};
    for (int i = 5; i < 8; i++)
      tbl[i] = '{3'(i), 32'hBAD0 + 32'(i), 5'b0, 32'h0, 1'b1};

    // Reset state
    reset_n       = 1'b0;
    bus.in_valid  = 1'b0;
    bus.in_sel    = '0;
    bus.in_data   = '0;
    bus.out_ready = 5'b11111;
    #12;
    chk("rst_in_ready",   64'(bus.in_ready), 64'(0));
    chk("rst_out_valid",  64'(bus.out_valid), 64'(0));
    chk("rst_out_data",   64'(bus.out_data), 64'(0));
    chk("rst_drop_cnt",   64'(drop_cnt), 64'(0));
    chk("rst_drop_pulse", 64'(drop_pulse), 64'(0));
    #10;
    reset_n = 1'b1;
    #1;
    chk("rel_in_ready_before_edge", 64'(bus.in_ready), 64'(0));
    cycle();
    chk("rel_in_ready_after_edge", 64'(bus.in_ready), 64'(1));

    // Table: one word per destination back to back, then three drops
    for (int i = 0; i < 8; i++) begin
      bus.in_valid = 1'b1;
      bus.in_sel   = tbl[i].sel;
      bus.in_data  = tbl[i].data;
      #1;
      chk("t1_in_ready", 64'(bus.in_ready), 64'(1));
      cycle();
      chk("t1_out_valid", 64'(bus.out_valid), 64'(tbl[i].exp_valid));
      if (tbl[i].exp_valid != 5'b0)
        chk("t1_out_data", 64'(bus.out_data), 64'(tbl[i].exp_data));
      chk("t1_drop_pulse", 64'(drop_pulse), 64'(tbl[i].exp_pulse));
    end
    bus.in_valid = 1'b0;
    cycle();
    chk("t1_idle_valid", 64'(bus.out_valid), 64'(0));
    chk("t1_idle_pulse", 64'(drop_pulse), 64'(0));
    chk("t1_drop_cnt",   64'(drop_cnt), 64'(3));

    // Stalled destination blocks a later word for another destination
    bus.out_ready = 5'b10111;
    bus.in_valid  = 1'b1;
    bus.in_sel    = 3'd3;
    bus.in_data   = 32'hDEAD_BEEF;
    cycle();
    bus.in_sel  = 3'd0;
    bus.in_data = 32'h1234_5678;
    for (int i = 0; i < 4; i++) begin
      chk("t2_hold_valid", 64'(bus.out_valid), 64'(5'b01000));
      chk("t2_hold_data",  64'(bus.out_data), 64'(32'hDEAD_BEEF));
      cycle();
      chk("t2_in_ready_full", 64'(bus.in_ready), 64'(0));
    end
    bus.out_ready = 5'b11111;
    cycle();
    bus.in_valid = 1'b0;
    chk("t2_second_valid", 64'(bus.out_valid), 64'(5'b00001));
    chk("t2_second_data",  64'(bus.out_data), 64'(32'h1234_5678));
    cycle();
    chk("t2_drained", 64'(bus.out_valid), 64'(0));

    // Drop counter saturation
    bus.in_valid = 1'b1;
    for (int i = 0; i < 300; i++) begin
      bus.in_sel  = 3'(5 + i % 3);
      bus.in_data = 32'(i);
      cycle();
      chk("t3_pulse", 64'(drop_pulse), 64'(1));
      chk("t3_no_out", 64'(bus.out_valid), 64'(0));
      if (i == 99) chk("t3_cnt_103", 64'(drop_cnt), 64'(103));
    end
    bus.in_valid = 1'b0;
    cycle();
    chk("t3_cnt_sat", 64'(drop_cnt), 64'(8'hFF));
    chk("t3_pulse_end", 64'(drop_pulse), 64'(0));

    // Asynchronous reset while a word is held
    bus.out_ready = 5'b11011;
    bus.in_valid  = 1'b1;
    bus.in_sel    = 3'd2;
    bus.in_data   = 32'hCAFE_F00D;
    cycle();
    bus.in_valid = 1'b0;
    #1;
    chk("t4_held", 64'(bus.out_valid), 64'(5'b00100));
    #1;
    reset_n = 1'b0;
    #1;
    chk("t4_rst_valid",    64'(bus.out_valid), 64'(0));
    chk("t4_rst_cnt",      64'(drop_cnt), 64'(0));
    chk("t4_rst_in_ready", 64'(bus.in_ready), 64'(0));
    #2;
    reset_n       = 1'b1;
    bus.out_ready = 5'b11111;
    for (int i = 0; i < 3; i++) begin
      cycle();
      chk("t4_no_stale", 64'(bus.out_valid), 64'(0));
    end

    // Full-rate stream with every destination ready
    bus.in_valid = 1'b1;
    for (int i = 0; i < 20; i++) begin
      bus.in_sel  = 3'(i % 5);
      bus.in_data = 32'(100 + i);
      #1;
      chk("t5_tput_ready", 64'(bus.in_ready), 64'(1));
      cycle();
      chk("t5_tput_valid", 64'(bus.out_valid), 64'(5'(1) << (i % 5)));
      chk("t5_tput_data",  64'(bus.out_data), 64'(100 + i));
    end
    bus.in_valid = 1'b0;
    cycle();

    // Random stream against the queue reference
    sent = 0;
    cyc  = 0;
    while (sent < 100 && cyc < 5000) begin
      if (!bus.in_valid && $urandom_range(0, 3) != 0) begin
        bus.in_valid = 1'b1;
        bus.in_sel   = 3'($urandom_range(0, 4));
        bus.in_data  = $urandom;
      end
      bus.out_ready = 5'($urandom) | 5'($urandom);
      #1;
      expv = (q.size() != 0) ? (5'(1) << q[0].sel) : 5'b0;
      chk("rnd_out_valid", 64'(bus.out_valid), 64'(expv));
      if (q.size() != 0) chk("rnd_out_data", 64'(bus.out_data), 64'(q[0].data));
      del = (q.size() != 0) && bus.out_ready[q[0].sel];
`ifdef DEMUX5_SKID_EN
      exp_rdy = q.size() < 2;
`else
      exp_rdy = (q.size() == 0) || del;
`endif
      chk("rnd_in_ready", 64'(bus.in_ready), 64'(exp_rdy));
      acc = bus.in_valid && bus.in_ready;
      cycle();
      cyc++;
      if (del) void'(q.pop_front());
      if (acc) begin
        q.push_back('{bus.in_sel, bus.in_data});
        sent++;
        bus.in_valid = 1'b0;
      end
    end
    chk("rnd_sent", 64'(sent), 64'(100));

    // Drain what is left in order
    bus.in_valid  = 1'b0;
    bus.out_ready = 5'b11111;
    for (int i = 0; i < 4; i++) begin
      #1;
      expv = (q.size() != 0) ? (5'(1) << q[0].sel) : 5'b0;
      chk("drain_valid", 64'(bus.out_valid), 64'(expv));
      if (q.size() != 0) chk("drain_data", 64'(bus.out_data), 64'(q[0].data));
      del = q.size() != 0;
      cycle();
      if (del) void'(q.pop_front());
    end
    chk("drain_empty", 64'(q.size()), 64'(0));
    chk("drain_idle",  64'(bus.out_valid), 64'(0));

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
